change_dispenser: RTL

- Payout back-end for the 15-rs vending controller.
- Accepts a change request in 5-rs units and pays it out as individual coins, preferring 10-rs coins, through the coin-ejector mechanism.
- Uses the same 2-bit coin encoding the controller uses for coin input, so the mechanism interface mirrors the acceptor side.
- Tracks 5-rs and 10-rs inventory, reports any unpaid remainder, and latches a fault if the mechanism stops acknowledging.

---
 rtl/vending_pkg.sv | 28 ++
 rtl/coin_inventory.sv | 37 +++
 rtl/change_dispenser.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the 15-rs vending controller: coin codes and the
// change-dispenser state encoding.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_EJECT = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } disp_state_e;

    // Value of a coin code in 5-rs units.
    function automatic logic [1:0] coin_units(input logic [1:0] coin);
        logic [1:0] units;
        case (coin)
            COIN_10: units = 2'd2;
            COIN_5:  units = 2'd1;
            default: units = 2'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Saturating up/down coin counter with a parameterised reset value.
// A simultaneous increment and decrement leaves the count unchanged.
module coin_inventory #(
    parameter int W    = 4,
    parameter int INIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX_CNT = {W{1'b1}};
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] INIT_V  = W'(INIT);

    logic [W-1:0] r_count;

    // Count register: refill saturates high, decrement never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= INIT_V;
        end else if (i_inc && !i_dec) begin
            if (r_count != MAX_CNT) begin
                r_count <= r_count + ONE;
            end
        end else if (!i_inc && i_dec) begin
            if (r_count != {W{1'b0}}) begin
                r_count <= r_count - ONE;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/change_dispenser.sv
// Change payout back-end: pays a request in 5-rs units as single coins,
// preferring 10-rs coins, and latches a fault if the ejector stops acking.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int INV_W       = 4,
    parameter int INIT_5      = 8,
    parameter int INIT_10     = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [3:0]       req_amt,
    output logic             req_ready,
    output logic [1:0]       eject,
    input  logic             eject_ack,
    output logic             done,
    output logic [3:0]       shortfall,
    output logic             fault,
    input  logic             load_5,
    input  logic             load_10,
    output logic [INV_W-1:0] cnt_5,
    output logic [INV_W-1:0] cnt_10
);

    localparam int             TMR_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    disp_state_e      r_state;
    logic             r_ready;
    logic [1:0]       r_eject;
    logic             r_done;
    logic [3:0]       r_shortfall;
    logic             r_fault;
    logic [3:0]       r_remaining;
    logic [TMR_W-1:0] r_timer;

    logic             w_ack_take;
    logic             w_dec_5;
    logic             w_dec_10;
    logic             w_can_10;
    logic             w_can_5;
    logic [INV_W-1:0] w_cnt_5;
    logic [INV_W-1:0] w_cnt_10;

    assign w_ack_take = (r_state == ST_EJECT) && eject_ack;
    assign w_dec_5    = w_ack_take && (r_eject == COIN_5);
    assign w_dec_10   = w_ack_take && (r_eject == COIN_10);
    assign w_can_10   = (r_remaining >= 4'd2) && (w_cnt_10 != {INV_W{1'b0}});
    assign w_can_5    = (r_remaining >= 4'd1) && (w_cnt_5 != {INV_W{1'b0}});

    coin_inventory #(.W(INV_W), .INIT(INIT_5)) u_inv_5 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (load_5),
        .i_dec   (w_dec_5),
        .o_count (w_cnt_5)
    );

    coin_inventory #(.W(INV_W), .INIT(INIT_10)) u_inv_10 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (load_10),
        .i_dec   (w_dec_10),
        .o_count (w_cnt_10)
    );

    // Payout sequencer; every output is a register updated with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_eject     <= COIN_NONE;
            r_done      <= 1'b0;
            r_shortfall <= 4'd0;
            r_fault     <= 1'b0;
            r_remaining <= 4'd0;
            r_timer     <= {TMR_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_remaining <= req_amt;
                        r_ready     <= 1'b0;
                        r_state     <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    r_timer <= {TMR_W{1'b0}};
                    if (w_can_10) begin
                        r_eject <= COIN_10;
                        r_state <= ST_EJECT;
                    end else if (w_can_5) begin
                        r_eject <= COIN_5;
                        r_state <= ST_EJECT;
                    end else begin
                        r_done      <= 1'b1;
                        r_shortfall <= r_remaining;
                        r_state     <= ST_DONE;
                    end
                end
                ST_EJECT: begin
                    // An ack on the last allowed cycle takes priority over the timeout.
                    if (eject_ack) begin
                        r_remaining <= r_remaining - {2'b00, coin_units(r_eject)};
                        r_eject     <= COIN_NONE;
                        r_timer     <= {TMR_W{1'b0}};
                        r_state     <= ST_SEL;
                    end else if (r_timer == TMO_LAST) begin
                        r_eject <= COIN_NONE;
                        r_fault <= 1'b1;
                        r_state <= ST_FAULT;
                    end else begin
                        r_timer <= r_timer + TMR_ONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_FAULT: begin
                    r_eject <= COIN_NONE;
                    r_ready <= 1'b0;
                    r_fault <= 1'b1;
                end
                default: begin
                    r_eject <= COIN_NONE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign eject     = r_eject;
    assign done      = r_done;
    assign shortfall = r_shortfall;
    assign fault     = r_fault;
    assign cnt_5     = w_cnt_5;
    assign cnt_10    = w_cnt_10;

endmodule
